// File: rtl/reaction_game_core.sv
// LED-vs-button reaction game: light one of N_CH LEDs, score a matching press before timeout.
// Optional LEVEL_SPEEDUP_EN: shrinks the response window every 8th hit and exposes a level count.
module reaction_game_core #(
    parameter int          N_CH        = 4,
    parameter int          TIMEOUT_CYC = 1000,
    parameter int          PAUSE_CYC   = 100,
    parameter int          LIVES       = 3,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               osc_clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [N_CH-1:0]    button,
    output logic [N_CH-1:0]    led,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives_left,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [1:0]         dbg_state
`ifdef LEVEL_SPEEDUP_EN
    ,
    output logic [2:0]         level
`endif
);

    localparam int TGT_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > PAUSE_CYC) ? TIMEOUT_CYC : PAUSE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAUSE = 2'd1,
        S_ARMED = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Input conditioning: 2-FF synchroniser plus a previous-value register per button.
    logic [N_CH-1:0] btn_s1_q, btn_s2_q, btn_prev_q;
    logic            start_prev_q;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [N_CH-1:0] btn_rise;
    logic            start_rise;

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_prev_q   <= '0;
            start_prev_q <= 1'b0;
            lfsr_q       <= SEED;
        end else begin
            btn_s1_q     <= button;
            btn_s2_q     <= btn_s1_q;
            btn_prev_q   <= btn_s2_q;
            start_prev_q <= start;
            lfsr_q       <= lfsr_d;
        end
    end

    // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    assign btn_rise   = btn_s2_q & ~btn_prev_q;
    assign start_rise = start & ~start_prev_q;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TGT_W-1:0]    target_q;
    logic [N_CH-1:0]     led_q;
    logic [SCORE_W-1:0]  score_q;
    logic [2:0]          lives_q;
    logic                over_q;
    logic                hit_q;
    logic                miss_q;

    logic [SCORE_W-1:0]  score_d;
    logic [2:0]          lives_d;
    logic [N_CH-1:0]     target_onehot;
    logic [N_CH-1:0]     next_onehot;
    logic [CNT_W-1:0]    timeout_last;

    assign target_onehot = N_CH'(1) << target_q;
    assign next_onehot   = N_CH'(1) << lfsr_q[TGT_W-1:0];

    always_comb begin
        score_d = score_q;
        if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1);
        end
        lives_d = lives_q - 3'd1;
    end

`ifdef LEVEL_SPEEDUP_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_FULL  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_FLOOR = TO_W'(TIMEOUT_CYC / 4);

    logic [TO_W-1:0] active_to_q, active_to_d;
    logic [2:0]      level_q, level_d;
    logic [2:0]      hits8_q;

    // Window shrinks by 1/8 of its current size, never below a quarter of the original.
    always_comb begin
        active_to_d = active_to_q - (active_to_q >> 3);
        if (active_to_d < TO_FLOOR) begin
            active_to_d = TO_FLOOR;
        end
        level_d = (level_q == 3'd7) ? level_q : level_q + 3'd1;
    end

    assign timeout_last = CNT_W'(active_to_q - TO_W'(1));
    assign level        = level_q;
`else
    assign timeout_last = CNT_W'(TIMEOUT_CYC - 1);
`endif

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            target_q    <= '0;
            led_q       <= '0;
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            over_q      <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
`ifdef LEVEL_SPEEDUP_EN
            active_to_q <= TO_FULL;
            level_q     <= '0;
            hits8_q     <= '0;
`endif
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (start_rise) begin
                // A start edge (re)starts from any state and never produces a pulse.
                state_q     <= S_PAUSE;
                cnt_q       <= '0;
                led_q       <= '0;
                score_q     <= '0;
                lives_q     <= 3'(LIVES);
                over_q      <= 1'b0;
`ifdef LEVEL_SPEEDUP_EN
                active_to_q <= TO_FULL;
                level_q     <= '0;
                hits8_q     <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        led_q <= '0;
                    end
                    S_PAUSE: begin
                        if (cnt_q == PAUSE_LAST) begin
                            state_q  <= S_ARMED;
                            target_q <= lfsr_q[TGT_W-1:0];
                            led_q    <= next_onehot;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_ARMED: begin
                        // A press always wins over a timeout landing in the same cycle.
                        if (btn_rise != '0) begin
                            if (btn_rise == target_onehot) begin
                                score_q <= score_d;
                                hit_q   <= 1'b1;
                                state_q <= S_PAUSE;
                                led_q   <= '0;
                                cnt_q   <= '0;
`ifdef LEVEL_SPEEDUP_EN
                                hits8_q <= hits8_q + 3'd1;
                                if (hits8_q == 3'd7) begin
                                    active_to_q <= active_to_d;
                                    level_q     <= level_d;
                                end
`endif
                            end else begin
                                miss_q  <= 1'b1;
                                lives_q <= lives_d;
                                cnt_q   <= '0;
                                if (lives_d == 3'd0) begin
                                    state_q <= S_OVER;
                                    led_q   <= '1;
                                    over_q  <= 1'b1;
                                end else begin
                                    state_q <= S_PAUSE;
                                    led_q   <= '0;
                                end
                            end
                        end else if (cnt_q == timeout_last) begin
                            miss_q  <= 1'b1;
                            lives_q <= lives_d;
                            cnt_q   <= '0;
                            if (lives_d == 3'd0) begin
                                state_q <= S_OVER;
                                led_q   <= '1;
                                over_q  <= 1'b1;
                            end else begin
                                state_q <= S_PAUSE;
                                led_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_OVER: begin
                        led_q  <= '1;
                        over_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        led_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign led        = led_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign game_over  = over_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/reaction_game_core.md
Name: reaction_game_core

Overview:
- Parametrised LED-vs-button reaction game core.
- Lights one of N_CH LEDs at a pseudo-random position; the player must press the matching button before a timeout.
- Tracks score and lives. Asserts game over when lives run out.
- Sits between the board button inputs (raw, asynchronous) and the LED bank. It is the next generation of the fixed 4-LED/4-button game block.

Parameters:
- N_CH, 4, number of LED/button channels; power of two, 2..16
- TIMEOUT_CYC, 1000, osc_clk cycles allowed for a response, >= 8
- PAUSE_CYC, 100, dark gap in cycles between rounds, >= 1
- LIVES, 3, misses allowed before game over, 1..7
- SCORE_W, 8, score counter width
- SEED, 16'hACE1, LFSR reset value, nonzero

Ports:
- osc_clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  synchronous to osc_clk; rising edge starts or restarts a game
- button  in  N_CH  raw active-high buttons, asynchronous
- led  out  N_CH  LED drive, active-high
- score  out  SCORE_W  hits in the current game
- lives_left  out  3  remaining lives
- game_over  out  1  high in OVER
- hit_pulse  out  1  one-cycle pulse on a correct press
- miss_pulse  out  1  one-cycle pulse on a wrong press or timeout

Behaviour:
- Clock and reset: one clock (osc_clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - led=0, score=0, lives_left=LIVES, game_over=0, pulses=0.
  - State IDLE, LFSR=SEED, all counters 0.
  - Asserting reset mid-game aborts immediately to these values.
- Button input path:
  - Per bit: 2-FF synchroniser, then a previous-value register. rise = sync2 & ~prev.
  - A button rise first sampled at edge k is acted on by the FSM at edge k+2.
  - hit_pulse or miss_pulse is high during the cycle after edge k+2.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle.
  - target = lfsr[log2(N_CH)-1:0], latched on PAUSE->ARMED.
- start edge detect: a registered previous value of start.
- IDLE:
  - led=0.
  - start rise -> PAUSE; score cleared, lives_left=LIVES.
- PAUSE:
  - led=0; button rises ignored; counter runs 0..PAUSE_CYC-1.
  - On reaching PAUSE_CYC-1 -> ARMED: latch target, clear timer.
- ARMED: led = one-hot(target); timer increments each cycle.
  - Hit: rise exactly equals one-hot(target).
    - score+1, saturating at 2^SCORE_W-1 (no wrap).
    - hit_pulse=1, -> PAUSE.
  - Miss (wrong press): any rise bit outside target, including target plus another in the same cycle.
  - Miss (timeout): timer == TIMEOUT_CYC-1 with no rise.
  - On a miss: miss_pulse=1, lives_left-1.
    - If the new value is 0 -> OVER, else -> PAUSE.
  - A rise in the same cycle as timeout: the press is evaluated and the timeout is ignored.
- OVER:
  - led = all ones, game_over=1; score and lives_left held.
  - start rise -> PAUSE with score=0, lives_left=LIVES, game_over=0.
- start rise in PAUSE or ARMED: restarts the game. Score and lives reload, -> PAUSE, no pulse.
- hit_pulse and miss_pulse are never high together.

Optional Feature:
- Macro: LEVEL_SPEEDUP_EN.
- When defined:
  - An active timeout register loads TIMEOUT_CYC at game start.
  - After every 8th hit (score[2:0] rolls to 0) it is reduced by active>>3.
  - Floor: TIMEOUT_CYC/4. The new value applies from the next ARMED round.
  - An additional output port level (3 bits) counts speedups, saturating at 7, and resets to 0 at game start.
- When undefined: timeout fixed at TIMEOUT_CYC and no level port.

Test Plan:
Common setup: N_CH=4, TIMEOUT_CYC=20, PAUSE_CYC=4, LIVES=3, SCORE_W=8.
1. Reset held 3 cycles, then released, no start -> led=0, score=0, lives_left=3, game_over=0 for 50 cycles.
2. start pulse; after ARMED, press the button matching the lit LED for 2 cycles -> hit_pulse exactly 1 cycle, 3 edges after the press; score=1; led=0 for 4 cycles, then a new one-hot LED.
3. In ARMED, press a non-lit button, and separately lit+non-lit together -> a miss_pulse each time; lives_left 3->2->1; score unchanged.
4. No presses after start -> a miss every 24+ cycles (20 armed + 4 pause). After the third miss: game_over=1, led=4'b1111, lives_left=0. A further start -> game_over=0, lives_left=3, score=0.
5. SCORE_W=2, 5 correct hits -> score sequence 1,2,3,3,3 (saturates).
6. reset_n low mid-ARMED with score=2 -> outputs take reset values asynchronously, before the next osc_clk edge. With LEVEL_SPEEDUP_EN: 8 hits -> next round times out after 18 cycles and level=1.
